// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, widths and baud helpers.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Clock cycles from start-edge detect to the middle of the start bit.
    function automatic int unsigned half_of(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Down-counting baud timer; tick marks the cycle the count reads zero.
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BAUD_CNT_W-1:0] load_val,
    output logic                  tick
);

    logic [BAUD_CNT_W-1:0] count_q;
    logic [BAUD_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q - 1'b1;
        if (load) begin
            count_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == '0) && !load;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with frame-error reporting.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIV  = 434,
    parameter int unsigned HALF = half_of(DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    logic                 rx_meta_q;
    logic                 rx_s_q;

    uart_state_e          state_q, state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 busy_q, busy_d;
    logic                 reload_q, reload_d;
    logic                 par_flag_q, par_flag_d;

    logic                  start_load;
    logic                  baud_load;
    logic [BAUD_CNT_W-1:0] baud_load_val;
    logic                  tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // The per-bit reload is applied the cycle after the sample so that load
    // never depends on tick; loading DIV-2 then keeps samples DIV cycles apart.
    assign baud_load     = start_load | reload_q;
    assign baud_load_val = reload_q ? BAUD_CNT_W'(DIV - 2) : BAUD_CNT_W'(HALF);

    uart_baud_cnt u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (baud_load),
        .load_val (baud_load_val),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        par_flag_d = par_flag_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        reload_d   = 1'b0;
        start_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d    = START;
                    start_load = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        reload_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    reload_d           = 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if ((^shift_q) ^ rx_s_q) begin
                        par_flag_d = 1'b1;
                    end
                    reload_d = 1'b1;
                    state_d  = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end else if (par_flag_q) begin
                        perr_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            par_flag_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            busy_q     <= 1'b0;
            reload_q   <= 1'b0;
            par_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            busy_q     <= busy_d;
            reload_q   <= reload_d;
            par_flag_q <= par_flag_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DIV=8 (80 ns bit time, 100 MHz clk).
module tb_uart_rx;

    localparam int unsigned DIV = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         valid_cnt   = 0;
    int         ferr_cnt    = 0;
    int         perr_cnt    = 0;
    int         overlap_cnt = 0;
    int         busy_at_pulse = 0;
    int         busy_cycles = 0;
    logic [7:0] last_data   = 8'h00;
    logic [7:0] prev_data   = 8'h00;

    uart_rx #(.DIV(DIV), .HALF(DIV / 2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            prev_data <= last_data;
            last_data <= rx_data;
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (rx_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
        if ((rx_valid || frame_err || parity_err) && busy) busy_at_pulse <= busy_at_pulse + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    // Full frame; bad_par inverts the even-parity bit when parity is compiled in.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);

        check("reset_rx_data",    32'(rx_data),    32'h00);
        check("reset_rx_valid",   32'(rx_valid),   32'h0);
        check("reset_frame_err",  32'(frame_err),  32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_busy",       32'(busy),       32'h0);

        // Clean 0xA5; busy spans start detect to mid-stop (77 cycles).
        busy_cycles = 0;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(16);
        check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("a5_data",      32'(rx_data),   32'hA5);
        check("a5_ferr_cnt",  32'(ferr_cnt),  32'd0);
        check("a5_busy_len",  32'(busy_cycles), 32'd77);
        check("a5_busy_idle", 32'(busy),      32'h0);

        // Two-cycle glitch: false start rejected at the mid-start sample.
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(2);
        check("glitch_busy_high", 32'(busy), 32'h1);
        idle(6);
        check("glitch_busy_low",  32'(busy),      32'h0);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd1);
        check("glitch_ferr_cnt",  32'(ferr_cnt),  32'd0);

        // 0x3C with a low stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        check("ferr_cnt",       32'(ferr_cnt),  32'd1);
        check("ferr_valid_cnt", 32'(valid_cnt), 32'd1);
        check("ferr_data_hold", 32'(rx_data),   32'hA5);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(16);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_first",     32'(prev_data), 32'h00);
        check("b2b_second",    32'(last_data), 32'hFF);
        check("b2b_ferr_cnt",  32'(ferr_cnt),  32'd1);

        // Reset in the middle of data bit 3 of 0x81 abandons the frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        idle(4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx  = 1'b1;
        idle(1);
        check("abort_data_cleared", 32'(rx_data), 32'h00);
        check("abort_busy",         32'(busy),    32'h0);
        idle(16);
        check("abort_valid_cnt", 32'(valid_cnt), 32'd3);
        check("abort_data_hold", 32'(rx_data),   32'h00);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(16);
        check("post_abort_valid_cnt", 32'(valid_cnt), 32'd4);
        check("post_abort_data",      32'(rx_data),   32'h7E);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h55, 1'b1, 1'b0);
        idle(16);
        check("par_ok_valid_cnt", 32'(valid_cnt), 32'd5);
        check("par_ok_data",      32'(rx_data),   32'h55);
        check("par_ok_perr_cnt",  32'(perr_cnt),  32'd0);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(16);
        check("par_bad_perr_cnt",  32'(perr_cnt),  32'd1);
        check("par_bad_valid_cnt", 32'(valid_cnt), 32'd5);
        check("par_bad_data_hold", 32'(rx_data),   32'h55);
`else
        check("no_parity_perr_cnt", 32'(perr_cnt), 32'd0);
`endif

        check("valid_ferr_overlap", 32'(overlap_cnt),   32'd0);
        check("busy_at_pulse",      32'(busy_at_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
